// File: rtl/title_dma_pkg.sv
// title_dma_pkg: shared FSM state, CSR offsets and CTRL/STATUS bit positions
package title_dma_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;
    localparam logic [1:0] CSR_SRC  = 2'd0;
    localparam logic [1:0] CSR_DST  = 2'd1;
    localparam logic [1:0] CSR_LEN  = 2'd2;
    localparam logic [1:0] CSR_CTRL = 2'd3;
    localparam int CTRL_GO  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_CLR = 2;
    localparam int ST_BUSY  = 0;
    localparam int ST_IE    = 1;
    localparam int ST_DONE  = 2;
endpackage

// File: rtl/title_dma_if.sv
// title_dma_if: CSR slave port, memory master port and interrupt of the DMA
interface title_dma_if #(parameter int ADDR_W = 32);
    logic              s_chipselect;
    logic              s_write;
    logic              s_read;
    logic [1:0]        s_address;
    logic [31:0]       s_writedata;
    logic [31:0]       s_readdata;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;
    logic              irq;
    modport master (
        input  s_chipselect, s_write, s_read, s_address, s_writedata,
        output s_readdata,
        output m_address, m_read, m_write, m_writedata,
        input  m_readdata, m_readdatavalid, m_waitrequest,
        output irq
    );
    modport slave (
        output s_chipselect, s_write, s_read, s_address, s_writedata,
        input  s_readdata,
        input  m_address, m_read, m_write, m_writedata,
        output m_readdata, m_readdatavalid, m_waitrequest,
        input  irq
    );
endinterface

// File: rtl/title_dma.sv
// title_dma: single-channel word-copy DMA with a 4-register CSR slave and
// a one-command-outstanding memory master.
module title_dma
    import title_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic clk,
    input  logic reset_n,
    title_dma_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       data_q, data_d, rdata_q, rdata_d;
    logic              done_q, done_d, ie_q, ie_d;
    logic              wr, rd, idle, ctrl_wr, go;

    assign wr      = bus.s_chipselect & bus.s_write;
    assign rd      = bus.s_chipselect & bus.s_read;
    assign idle    = state_q == IDLE;
    assign ctrl_wr = wr && bus.s_address == CSR_CTRL;
    assign go      = ctrl_wr && bus.s_writedata[CTRL_GO] && idle;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        done_d  = done_q;
        ie_d    = ie_q;
        rdata_d = rdata_q;
        if (wr && idle && bus.s_address == CSR_SRC) src_d = bus.s_writedata[ADDR_W-1:0];
        if (wr && idle && bus.s_address == CSR_DST) dst_d = bus.s_writedata[ADDR_W-1:0];
        if (wr && idle && bus.s_address == CSR_LEN) len_d = bus.s_writedata[LEN_W-1:0];
        if (ctrl_wr && bus.s_writedata[CTRL_CLR]) done_d = 1'b0;
        // go overrides clear; a zero-length go completes immediately
        if (go) begin
            ie_d    = bus.s_writedata[CTRL_IE];
            done_d  = len_q == '0;
            state_d = len_q == '0 ? IDLE : RD_REQ;
        end
        case (state_q)
            RD_REQ:  if (!bus.m_waitrequest) state_d = RD_WAIT;
            RD_WAIT: if (bus.m_readdatavalid) begin
                data_d  = bus.m_readdata;
                state_d = WR_REQ;
            end
            WR_REQ:  if (!bus.m_waitrequest) begin
                src_d   = src_q + ADDR_W'(4);
                dst_d   = dst_q + ADDR_W'(4);
                len_d   = len_q - LEN_W'(1);
                done_d  = len_q == LEN_W'(1);
                state_d = len_q == LEN_W'(1) ? IDLE : RD_REQ;
            end
            default: ;
        endcase
        if (rd) rdata_d = bus.s_address == CSR_SRC ? 32'(src_q) :
                          bus.s_address == CSR_DST ? 32'(dst_q) :
                          bus.s_address == CSR_LEN ? 32'(len_q) :
                          {29'b0, done_q, ie_q, !idle};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ie_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ie_q    <= ie_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.s_readdata  = rdata_q;
    assign bus.m_read      = state_q == RD_REQ;
    assign bus.m_write     = state_q == WR_REQ;
    assign bus.m_address   = state_q == WR_REQ ? dst_q : src_q;
    assign bus.m_writedata = data_q;
    assign bus.irq         = done_q & ie_q;
endmodule

// File: doc/title_dma.md
TITLE_DMA -- requirements
Module: title_dma

Parameters
REQ-001 SHALL: ADDR_W, 32, master byte-address width.
REQ-002 SHALL: LEN_W, 16, word-count register width.

Interface
REQ-003 SHALL: clk  in  1  sole clock; all flops rise on it.
REQ-004 SHALL: reset_n  in  1  asynchronous assert, active-low reset.
REQ-005 SHALL: s_chipselect  in  1  CSR slave select.
REQ-006 SHALL: s_write / s_read  in  1 each  CSR write / read strobes.
REQ-007 SHALL: s_address  in  2  CSR word select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS.
REQ-008 SHALL: s_writedata  in  32  CSR write data.
REQ-009 SHALL: s_readdata  out  32  CSR read data, fixed read latency 1.
REQ-010 SHALL: m_address  out  ADDR_W  master byte address.
REQ-011 SHALL: m_read / m_write  out  1 each  master strobes.
REQ-012 SHALL: m_writedata  out  32  master write data.
REQ-013 SHALL: m_readdata  in  32  master read data.
REQ-014 SHALL: m_readdatavalid  in  1  read data valid; may arrive 1+ cycles after the accepted read.
REQ-015 SHALL: m_waitrequest  in  1  slave stall; a command is accepted only in a cycle with m_waitrequest low.
REQ-016 SHALL: irq  out  1  level interrupt, high while done is set and CTRL bit1 (ie) is set.

Function
REQ-017 SHALL: Writes to SRC/DST/LEN while idle load the registers; writes to them while busy are ignored.
REQ-018 SHALL: A CTRL write with bit0=1 while idle starts a transfer: it clears done and latches ie from bit1; with bit0=1 while busy, bit0 is ignored.
REQ-019 SHALL: A CTRL write with bit2=1 clears done; a simultaneous go=1 wins, so done ends cleared and the transfer starts.
REQ-020 SHALL: STATUS read returns {29'b0, done, ie, busy}; SRC/DST/LEN reads return the current working values.
REQ-021 SHALL: The FSM has states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-022 SHALL: IDLE -> RD_REQ on go with LEN != 0; go with LEN == 0 sets done in the next cycle and stays in IDLE.
REQ-023 SHALL: RD_REQ asserts m_read with m_address = SRC and holds both stable until accepted, then moves to RD_WAIT.
REQ-024 SHALL: RD_WAIT captures m_readdata on m_readdatavalid into a data register, then moves to WR_REQ.
REQ-025 SHALL: WR_REQ asserts m_write with m_address = DST and m_writedata = the data register, held stable until accepted.
REQ-026 SHALL: On write acceptance: SRC += 4, DST += 4, LEN -= 1 (modulo 2^ADDR_W; wraparound allowed); if the new LEN is 0, go to IDLE and set done, else go to RD_REQ.
REQ-027 SHALL: At most one master command is outstanding; m_read and m_write are never high together.
REQ-028 SHALL: busy = (state != IDLE).
REQ-029 SHALL: m_readdatavalid outside RD_WAIT is ignored.

Reset
REQ-030 SHALL: Asserting reset_n low at any time, including mid-transfer, immediately forces IDLE; SRC, DST, LEN, data, done, ie and s_readdata go to 0; m_read, m_write and irq go low.
REQ-031 SHALL: Deassertion of reset_n is synchronized externally; the block needs no internal synchronizer.

Structure
REQ-032 SHALL: A shared package title_dma_pkg holds the state enum, the CSR offset constants and the CTRL/STATUS bit positions.
REQ-033 SHALL: The block is one module; the CSR slave and the master FSM stay inside it, with no sub-module.

Verification
REQ-034 SHALL: SRC=0x1000, DST=0x2000, LEN=3, go, zero-wait memory -> three reads at 0x1000/4/8 and three writes at 0x2000/4/8 with matching data, then done=1, busy=0.
REQ-035 SHALL: Same transfer with m_waitrequest randomly high 50% of cycles and readdatavalid delayed 0-5 cycles -> the same address/data sequence, with command signals stable while stalled.
REQ-036 SHALL: LEN=0, go -> no master strobes; STATUS reads 0b100 two cycles later.
REQ-037 SHALL: go with ie=1, LEN=1 -> irq rises with done; a CTRL write of 0x4 drops irq the next cycle.
REQ-038 SHALL: reset_n pulsed low during WR_REQ -> m_write drops asynchronously and STATUS reads 0 after release.
REQ-039 SHALL: SRC write while busy -> the SRC readback is unchanged and the transfer addresses are unaffected.
